// File: rtl/pc_next_unit.sv
// Program counter with branch/jump redirect and a registered redirect pulse.
// Define BRANCH_DELAY_SLOT_EN to execute one delay-slot instruction before a redirect takes effect.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [15:0] imm,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        redirect
);

  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;
  logic [31:0] target_s;
  logic        redirect_r;
  logic        redirect_nxt_s;
  logic        take_s;

  assign pc        = pc_r;
  assign redirect  = redirect_r;
  assign pc_plus_4 = pc_r + 32'd4;

  // Jump beats a taken branch; arithmetic wraps naturally at 32 bits.
  assign branch_target_s = pc_plus_4 + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target_s   = {pc_plus_4[31:28], jump_index, 2'b00};
  assign take_s          = jump | (branch & zero);
  assign target_s        = jump ? jump_target_s : branch_target_s;

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] target_r;
  logic [31:0] target_nxt_s;

  // Next state: SEQ latches a redirect target, SLOT releases it after the slot instruction.
  always_comb begin
    pc_nxt_s       = pc_plus_4;
    redirect_nxt_s = 1'b0;
    state_nxt_s    = state_r;
    target_nxt_s   = target_r;
    case (state_r)
      SEQ: begin
        if (take_s) begin
          target_nxt_s = target_s;
          state_nxt_s  = SLOT;
        end else begin
          state_nxt_s  = SEQ;
        end
      end
      SLOT: begin
        pc_nxt_s       = target_r;
        redirect_nxt_s = 1'b1;
        state_nxt_s    = SEQ;
      end
      default: begin
        state_nxt_s = SEQ;
      end
    endcase
  end

  // State register; stall freezes everything, reset discards any pending target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_VECTOR;
      redirect_r <= 1'b0;
      state_r    <= SEQ;
      target_r   <= 32'h0000_0000;
    end else if (!stall) begin
      pc_r       <= pc_nxt_s;
      redirect_r <= redirect_nxt_s;
      state_r    <= state_nxt_s;
      target_r   <= target_nxt_s;
    end else begin
      pc_r       <= pc_r;
      redirect_r <= redirect_r;
      state_r    <= state_r;
      target_r   <= target_r;
    end
  end
`else
  // Next PC: redirect immediately on a jump or taken branch.
  always_comb begin
    pc_nxt_s       = pc_plus_4;
    redirect_nxt_s = 1'b0;
    if (take_s) begin
      pc_nxt_s       = target_s;
      redirect_nxt_s = 1'b1;
    end else begin
      pc_nxt_s       = pc_plus_4;
      redirect_nxt_s = 1'b0;
    end
  end

  // PC register; stall freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_VECTOR;
      redirect_r <= 1'b0;
    end else if (!stall) begin
      pc_r       <= pc_nxt_s;
      redirect_r <= redirect_nxt_s;
    end else begin
      pc_r       <= pc_r;
      redirect_r <= redirect_r;
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: three instances with different reset vectors
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_pc_next_unit;

  localparam logic [31:0] RV0 = 32'h0040_0000;
  localparam logic [31:0] RV1 = 32'h3000_0000;
  localparam logic [31:0] RV2 = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [15:0] imm;
  logic [25:0] jump_index;
  logic [31:0] pc_o  [3];
  logic [31:0] pp4_o [3];
  logic        red_o [3];

  logic [31:0] m_pc  [3];
  logic        m_red [3];
`ifdef BRANCH_DELAY_SLOT_EN
  logic        m_pv  [3];
  logic [31:0] m_pt  [3];
`endif

  int tests = 0;
  int fails = 0;

  pc_next_unit #(.RESET_VECTOR(RV0)) u0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero), .jump(jump),
    .imm(imm), .jump_index(jump_index), .pc(pc_o[0]), .pc_plus_4(pp4_o[0]), .redirect(red_o[0]));
  pc_next_unit #(.RESET_VECTOR(RV1)) u1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero), .jump(jump),
    .imm(imm), .jump_index(jump_index), .pc(pc_o[1]), .pc_plus_4(pp4_o[1]), .redirect(red_o[1]));
  pc_next_unit #(.RESET_VECTOR(RV2)) u2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero), .jump(jump),
    .imm(imm), .jump_index(jump_index), .pc(pc_o[2]), .pc_plus_4(pp4_o[2]), .redirect(red_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rv_of(input int i);
    return (i == 0) ? RV0 : ((i == 1) ? RV1 : RV2);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Architectural model: what the next PC should be, from the rules, not the RTL structure.
  task automatic model_step(input int i);
    logic [31:0] ppl4;
    logic [31:0] tgt;
    logic        taken;
    int          off;
    if (!rst_n) begin
      m_pc[i]  = rv_of(i);
      m_red[i] = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      m_pv[i]  = 1'b0;
      m_pt[i]  = 32'h0;
`endif
    end else if (!stall) begin
      ppl4  = m_pc[i] + 32'd4;
      taken = jump || (branch && zero);
      off   = int'($signed(imm)) * 4;
      tgt   = jump ? {ppl4[31:28], jump_index, 2'b00} : ppl4 + 32'(off);
`ifdef BRANCH_DELAY_SLOT_EN
      if (m_pv[i]) begin
        m_pc[i] = m_pt[i]; m_red[i] = 1'b1; m_pv[i] = 1'b0;
      end else if (taken) begin
        m_pt[i] = tgt; m_pv[i] = 1'b1; m_pc[i] = ppl4; m_red[i] = 1'b0;
      end else begin
        m_pc[i] = ppl4; m_red[i] = 1'b0;
      end
`else
      m_pc[i]  = taken ? tgt : ppl4;
      m_red[i] = taken;
`endif
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check32($sformatf("model_pc[%0d]", i), pc_o[i], m_pc[i]);
      check32($sformatf("model_pp4[%0d]", i), pp4_o[i], m_pc[i] + 32'd4);
      check1($sformatf("model_red[%0d]", i), red_o[i], m_red[i]);
    end
  endtask

  task automatic idle_in();
    rst_n = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    imm = 16'h0000; jump_index = 26'h0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    idle_in();
  endtask

  initial begin
    // Reset overrides stall, jump and branch
    idle_in();
    rst_n = 1'b0; stall = 1'b1; branch = 1'b1; zero = 1'b1; jump = 1'b1;
    jump_index = 26'h3FF_FFFF;
    tick();
    tick();
    check32("rst_pc0", pc_o[0], 32'h0040_0000);
    check1 ("rst_red0", red_o[0], 1'b0);
    check32("rst_pc1", pc_o[1], 32'h3000_0000);
    check32("rst_pc2", pc_o[2], 32'hFFFF_FFF8);
    check32("rst_pp4_0", pp4_o[0], 32'h0040_0004);

    // Free-running sequence and sequential wrap
    idle_in();
    tick(); check32("seq_pc_1", pc_o[0], 32'h0040_0004); check1("seq_red_1", red_o[0], 1'b0);
    tick(); check32("seq_pc_2", pc_o[0], 32'h0040_0008); check1("seq_red_2", red_o[0], 1'b0);
    check32("wrap_seq", pc_o[2], 32'h0000_0000);
    tick(); check32("seq_pc_3", pc_o[0], 32'h0040_000C); check1("seq_red_3", red_o[0], 1'b0);

    // Jump and taken branch together: jump wins
    do_reset();
    jump = 1'b1; branch = 1'b1; zero = 1'b1; imm = 16'h0100; jump_index = 26'h000_0010;
    tick();
`ifdef BRANCH_DELAY_SLOT_EN
    check32("jmp_slot_pc", pc_o[1], 32'h3000_0004); check1("jmp_slot_red", red_o[1], 1'b0);
    idle_in(); jump = 1'b1; jump_index = 26'h000_0020;
    tick();
`endif
    check32("jmp_pc", pc_o[1], 32'h3000_0040); check1("jmp_red", red_o[1], 1'b1);
    idle_in();
    tick(); check32("jmp_after_pc", pc_o[1], 32'h3000_0044); check1("jmp_after_red", red_o[1], 1'b0);

    // Backward branch from 0x100
    do_reset();
    jump = 1'b1; jump_index = 26'h000_0040;
    tick();
`ifdef BRANCH_DELAY_SLOT_EN
    idle_in();
    tick();
`endif
    check32("to100_pc", pc_o[0], 32'h0000_0100);
    idle_in(); branch = 1'b1; zero = 1'b1; imm = 16'hFFFE;
    tick();
`ifdef BRANCH_DELAY_SLOT_EN
    check32("br_slot_pc", pc_o[0], 32'h0000_0104); check1("br_slot_red", red_o[0], 1'b0);
    idle_in();
    tick();
`endif
    check32("br_pc", pc_o[0], 32'h0000_00FC); check1("br_red", red_o[0], 1'b1);
    idle_in();
    tick(); check32("br_after_pc", pc_o[0], 32'h0000_0100); check1("br_after_red", red_o[0], 1'b0);

    // Branch not taken when zero=0
    branch = 1'b1; zero = 1'b0; imm = 16'hFFFE;
    tick(); check32("br_nt_pc", pc_o[0], 32'h0000_0104); check1("br_nt_red", red_o[0], 1'b0);

    // Jump seen only while stalled is ignored
    idle_in(); stall = 1'b1; jump = 1'b1; jump_index = 26'h000_0003;
    for (int k = 0; k < 3; k++) begin
      tick();
      check32("stall_pc", pc_o[0], 32'h0000_0104);
      check1 ("stall_red", red_o[0], 1'b0);
    end
    idle_in();
    tick(); check32("unstall_pc", pc_o[0], 32'h0000_0108); check1("unstall_red", red_o[0], 1'b0);
    tick(); check1("unstall_red2", red_o[0], 1'b0);

    // Branch target wrap
    do_reset();
    branch = 1'b1; zero = 1'b1; imm = 16'h0001;
    tick();
`ifdef BRANCH_DELAY_SLOT_EN
    check32("wrap_br_slot", pc_o[2], 32'hFFFF_FFFC);
    idle_in();
    tick();
`endif
    check32("wrap_br_pc", pc_o[2], 32'h0000_0000); check1("wrap_br_red", red_o[2], 1'b1);

    // Reset right after a redirecting input discards any pending target
    do_reset();
    jump = 1'b1; jump_index = 26'h000_0040;
    tick();
    idle_in(); rst_n = 1'b0;
    tick(); check32("rst_slot_pc", pc_o[0], 32'h0040_0000); check1("rst_slot_red", red_o[0], 1'b0);
    idle_in();
    tick(); check32("post_rst_pc1", pc_o[0], 32'h0040_0004); check1("post_rst_red1", red_o[0], 1'b0);
    tick(); check32("post_rst_pc2", pc_o[0], 32'h0040_0008); check1("post_rst_red2", red_o[0], 1'b0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 31) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch     = 1'($urandom);
      zero       = 1'($urandom);
      jump       = ($urandom_range(0, 3) == 0);
      imm        = 16'($urandom);
      jump_index = 26'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
